// File: rtl/program_loader.sv
// Boot loader: takes a length header and big-endian 32-bit words from a byte stream,
// writes them to instruction memory, then releases the cpu from reset.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           words_loaded,
  output logic [2:0]            fsm_state
);

  // Stream handshake: a byte moves on a rising edge where in_valid and in_ready are both 1;
  // in_ready depends only on the current state and load_start, never on in_valid.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0]           MAX_WORDS = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t      state, state_next;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [15:0] hdr_len;
  logic        accept;

  assign in_ready  = ((state == HDR_HI) || (state == HDR_LO) || (state == DATA)) && !load_start;
  assign accept    = in_valid && in_ready;
  assign hdr_len   = {len[15:8], in_data};
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   state_next = IDLE;
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_len == 16'd0)                state_next = RUN;
          else if ({1'b0, hdr_len} > MAX_WORDS) state_next = ERR;
          else                                 state_next = DATA;
        end
      end
      DATA:   if (accept && (byte_cnt == 2'd3)) state_next = WRITE;
      WRITE:  state_next = ((words_loaded + 16'd1) == len) ? RUN : DATA;
      RUN:    state_next = RUN;
      ERR:    state_next = ERR;
      default: state_next = IDLE;
    endcase
    if (load_start) state_next = HDR_HI;
  end

  // Status outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      cpu_reset  <= 1'b1;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we    <= (state_next == WRITE);
      cpu_reset  <= (state_next != RUN);
      cpu_enable <= (state_next == RUN);
      busy       <= (state_next == HDR_HI) || (state_next == HDR_LO) ||
                    (state_next == DATA)   || (state_next == WRITE);
      error      <= (state_next == ERR);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      imem_addr    <= BASE;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
    end else if (load_start) begin
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      imem_addr    <= BASE;
      words_loaded <= 16'd0;
    end else begin
      if (accept && (state == HDR_HI)) len[15:8] <= in_data;
      if (accept && (state == HDR_LO)) len[7:0]  <= in_data;
      if (accept && (state == DATA)) begin
        imem_wdata <= {imem_wdata[23:0], in_data};
        byte_cnt   <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        imem_addr    <= imem_addr + ADDR_ONE;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: basic load, gapped stream, length error,
// zero length, abort mid-word and asynchronous reset.
module tb_program_loader;

  localparam logic [2:0] S_IDLE = 3'd0, S_HDR_HI = 3'd1, S_DATA = 3'd3,
                         S_WRITE = 3'd4, S_RUN = 3'd5, S_ERR = 3'd6;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset, cpu_enable, busy, error;
  logic [15:0] words_loaded;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  logic [39:0] exp_q[$];

  logic [7:0] t1_bytes[10] = '{8'h00, 8'h02, 8'h8D, 8'h09, 8'h00, 8'h00, 8'hAD, 8'h0D, 8'h00, 8'h00};
  int         t2_gaps[10]  = '{1, 1, 1, 3, 1, 1, 0, 1, 1, 1};

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .busy(busy),
    .error(error), .words_loaded(words_loaded), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clock) begin
    if (cpu_enable === 1'b1 && cpu_reset === 1'b1) overlap_cnt++;
    if (imem_we === 1'b1) begin
      check("write_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  // Driver tasks start and end #1 after a rising edge.
  task automatic pulse_load();
    load_start = 1'b1;
    #1 check("ready_during_load", in_ready, 0);
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got_ready = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin got_ready = 1'b1; break; end
    end
    if (!got_ready) check("ready_timeout", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    check("rst_state", fsm_state, S_IDLE);
    check("rst_outs", {imem_we, cpu_reset, cpu_enable, busy, error, in_ready}, 6'b010000);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_words", words_loaded, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // T1 basic two-word load
    exp_q.push_back({8'h00, 32'h8D090000});
    exp_q.push_back({8'h01, 32'hAD0D0000});
    pulse_load();
    check("t1_hdr_state", fsm_state, S_HDR_HI);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 10; i++) send_byte(t1_bytes[i], 0);
    @(negedge clock);
    check("t1_write_state", fsm_state, S_WRITE);
    check("t1_write_ready", in_ready, 0);
    check("t1_pre_run_en", cpu_enable, 0);
    @(negedge clock);
    check("t1_run_state", fsm_state, S_RUN);
    check("t1_run_ctl", {cpu_enable, cpu_reset, busy, imem_we}, 4'b1000);
    check("t1_words", words_loaded, 2);
    check("t1_drained", exp_q.size(), 0);
    @(posedge clock); #1;

    // T2 gapped stream with valid toggling and a mid-word stall
    exp_q.push_back({8'h00, 32'h8D090000});
    exp_q.push_back({8'h01, 32'hAD0D0000});
    pulse_load();
    check("t2_en_drop", cpu_enable, 0);
    for (int i = 0; i < 10; i++) send_byte(t1_bytes[i], t2_gaps[i]);
    @(negedge clock);
    check("t2_write_ready", in_ready, 0);
    @(negedge clock);
    check("t2_run_state", fsm_state, S_RUN);
    check("t2_words", words_loaded, 2);
    check("t2_drained", exp_q.size(), 0);
    @(posedge clock); #1;

    // T3 length error (257 > 256)
    pulse_load();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clock);
    check("t3_err_state", fsm_state, S_ERR);
    check("t3_err_outs", {error, cpu_reset, cpu_enable, in_ready, busy}, 5'b11000);
    @(posedge clock); #1;
    pulse_load();
    @(negedge clock);
    check("t3_err_clear", error, 0);
    check("t3_hdr_state", fsm_state, S_HDR_HI);
    @(posedge clock); #1;

    // T4 zero length
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clock);
    check("t4_run_state", fsm_state, S_RUN);
    check("t4_run_ctl", {cpu_enable, cpu_reset}, 2'b10);
    check("t4_words", words_loaded, 0);
    @(posedge clock); #1;

    // T5 abort from RUN and mid-word, then reload one word
    exp_q.push_back({8'h00, 32'h11223344});
    pulse_load();
    @(negedge clock);
    check("t5_en_drop", {cpu_enable, cpu_reset}, 2'b01);
    @(posedge clock); #1;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    pulse_load();
    in_valid = 1'b0;
    @(negedge clock);
    check("t5_abort_state", fsm_state, S_HDR_HI);
    check("t5_abort_addr", imem_addr, 0);
    check("t5_abort_words", words_loaded, 0);
    @(posedge clock); #1;
    exp_q.push_back({8'h00, 32'hA1B2C3D4});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    repeat (2) @(negedge clock);
    check("t5_run_state", fsm_state, S_RUN);
    check("t5_words", words_loaded, 1);
    check("t5_drained", exp_q.size(), 0);
    @(posedge clock); #1;

    // T6 asynchronous reset mid-DATA
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("t6_pre_state", fsm_state, S_DATA);
    #2 reset = 1'b0;
    #1;
    check("t6_async_state", fsm_state, S_IDLE);
    check("t6_async_outs", {imem_we, cpu_reset, cpu_enable, busy, error}, 5'b01000);
    check("t6_async_wdata", imem_wdata, 0);
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("t6_stay_idle", fsm_state, S_IDLE);
    check("t6_idle_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clock);

    check("no_overlap", overlap_cnt, 0);
    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
